// File: rtl/mips_trace_buffer_pkg.sv
// Shared definitions for the MIPS trace buffer.
//   - capture FSM state encoding (also the state_o encoding)
//   - trace record field widths and packing order
//   - saturating increment for the 16-bit captured-record counter
package mips_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } trace_state_e;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int REC_W   = PC_W + INSTR_W + 1 + ADDR_W + DATA_W;  // 129
  localparam int CNT_W   = 16;

  // Packing order {pc, instr, dm_we, dm_addr, dm_wdata}, pc in the MSBs.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               dm_we;
    logic [ADDR_W-1:0]  dm_addr;
    logic [DATA_W-1:0]  dm_wdata;
  } trace_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mips_trace_buffer_fifo.sv
// First-word-fall-through FIFO with optional overwrite-oldest on full.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write request and record
//   pop_req           consumer ready; a pop only happens when non-empty
//   valid, rdata      head record (rdata forced to 0 when empty)
//   count             occupancy, AW+1 bits
//   dropped           push refused (full, no pop, WRAP=0)
//   overwrote         push accepted by discarding the oldest record
module mips_trace_buffer_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WRAP  = 0,
  parameter int W     = 129
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop_req,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic [AW:0]  count,
  output logic         dropped,
  output logic         overwrote
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          adv_rd;
  logic          wrap_en;

  assign wrap_en   = (WRAP != 0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign valid     = (count != '0);
  assign pop       = pop_req & valid;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok   = push & (~full | pop | wrap_en);
  assign overwrote = push & full & ~pop & wrap_en;
  assign dropped   = push & ~push_ok;
  assign adv_rd    = pop | overwrote;
  assign rdata     = valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (adv_rd)  rptr <= rptr + 1'b1;
      if (push_ok && !adv_rd)      count <= count + 1'b1;
      else if (!push_ok && adv_rd) count <= count - 1'b1;
    end
  end

  // Storage is not reset; the read side is gated by valid instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Trigger-armed trace capture for the single-cycle MIPS core.
// One record {pc, instr, dm_we, dm_addr, dm_wdata} per retired instruction
// is pushed into a FWFT FIFO once the trigger PC has been seen.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   retire, pc_in, instr_in,
//   dm_we_in, dm_addr_in,
//   dm_wdata_in              retiring-instruction debug stream from the core
//   arm, abort               control pulses (abort wins over everything)
//   trig_pc, cap_len         trigger PC and record limit (0 = unlimited)
//   rd_ready / rd_valid, rd_*   FWFT read port
//   state_o, overflow, count_o  status
//
// state   | meaning
// IDLE    | not capturing; waits for arm
// ARMED   | waiting for a retire at trig_pc (that record is stored)
// CAPTURE | storing every retire
// DONE    | cap_len reached or FIFO full without wrap; waits for arm
module mips_trace_buffer
  import mips_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WRAP  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        dm_we_in,
  input  logic [31:0] dm_addr_in,
  input  logic [31:0] dm_wdata_in,
  input  logic        arm,
  input  logic        abort,
  input  logic [31:0] trig_pc,
  input  logic [15:0] cap_len,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_pc,
  output logic [31:0] rd_instr,
  output logic        rd_dm_we,
  output logic [31:0] rd_dm_addr,
  output logic [31:0] rd_dm_wdata,
  output logic [1:0]  state_o,
  output logic        overflow,
  output logic [AW:0] count_o
);

  trace_state_e     state;
  logic [CNT_W-1:0] cap_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             push_req;
  logic             dropped;
  logic             overwrote;
  trace_rec_t       wrec;
  trace_rec_t       hrec;

  assign push_req = retire & ~abort &
                    ((state == ST_CAPTURE) | ((state == ST_ARMED) & (pc_in == trig_pc)));
  assign cnt_next = sat_inc(cap_cnt);
  assign wrec     = {pc_in, instr_in, dm_we_in, dm_addr_in, dm_wdata_in};

  mips_trace_buffer_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WRAP  (WRAP),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_req),
    .wdata     (wrec),
    .pop_req   (rd_ready),
    .valid     (rd_valid),
    .rdata     (hrec),
    .count     (count_o),
    .dropped   (dropped),
    .overwrote (overwrote)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cap_cnt  <= '0;
      overflow <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state    <= ST_ARMED;
            cap_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (push_req) begin
            if (dropped) begin
              overflow <= 1'b1;
              state    <= ST_DONE;
            end else begin
              cap_cnt <= cnt_next;
              if (overwrote) overflow <= 1'b1;
              // cap_len=1 finishes on the trigger record itself.
              if ((cap_len != '0) && (cnt_next == cap_len)) state <= ST_DONE;
              else                                          state <= ST_CAPTURE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_o     = state;
  assign rd_pc       = hrec.pc;
  assign rd_instr    = hrec.instr;
  assign rd_dm_we    = hrec.dm_we;
  assign rd_dm_addr  = hrec.dm_addr;
  assign rd_dm_wdata = hrec.dm_wdata;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: three instances (16-deep no-wrap, 4-deep
// no-wrap, 4-deep wrap) share one stimulus stream and are compared every
// cycle against a queue-based reference model.
module tb_mips_trace_buffer;
  import mips_trace_buffer_pkg::*;

  localparam int ND = 3;

  function automatic int dep_of(input int g);
    return (g == 0) ? 16 : 4;
  endfunction

  function automatic int wrap_of(input int g);
    return (g == 2) ? 1 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic        dm_we_in = 1'b0;
  logic [31:0] dm_addr_in = '0;
  logic [31:0] dm_wdata_in = '0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] trig_pc = '0;
  logic [15:0] cap_len = '0;
  logic        rd_ready = 1'b0;

  logic        o_valid [ND];
  logic [31:0] o_pc    [ND];
  logic [31:0] o_instr [ND];
  logic        o_we    [ND];
  logic [31:0] o_addr  [ND];
  logic [31:0] o_wdata [ND];
  logic [1:0]  o_state [ND];
  logic        o_ovf   [ND];
  logic [4:0]  o_cnt   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int D = dep_of(g);
    localparam int A = $clog2(D);
    logic [A:0] cnt;
    mips_trace_buffer #(.DEPTH(D), .AW(A), .WRAP(wrap_of(g))) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .retire      (retire),
      .pc_in       (pc_in),
      .instr_in    (instr_in),
      .dm_we_in    (dm_we_in),
      .dm_addr_in  (dm_addr_in),
      .dm_wdata_in (dm_wdata_in),
      .arm         (arm),
      .abort       (abort),
      .trig_pc     (trig_pc),
      .cap_len     (cap_len),
      .rd_ready    (rd_ready),
      .rd_valid    (o_valid[g]),
      .rd_pc       (o_pc[g]),
      .rd_instr    (o_instr[g]),
      .rd_dm_we    (o_we[g]),
      .rd_dm_addr  (o_addr[g]),
      .rd_dm_wdata (o_wdata[g]),
      .state_o     (o_state[g]),
      .overflow    (o_ovf[g]),
      .count_o     (cnt)
    );
    assign o_cnt[g] = 5'(cnt);
  end

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: plain queues and spec-level rules.
  trace_rec_t mq [ND][$];
  int         m_state [ND];   // 0 idle, 1 armed, 2 capture, 3 done
  int         m_cnt   [ND];
  bit         m_ovf   [ND];

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      mq[k].delete();
      m_state[k] = 0;
      m_cnt[k]   = 0;
      m_ovf[k]   = 1'b0;
    end
  endtask

  task automatic model_step();
    trace_rec_t r;
    int st0;
    bit pop_ok, push_req, accept;
    r.pc = pc_in; r.instr = instr_in; r.dm_we = dm_we_in;
    r.dm_addr = dm_addr_in; r.dm_wdata = dm_wdata_in;
    for (int k = 0; k < ND; k++) begin
      st0      = m_state[k];
      pop_ok   = rd_ready && (mq[k].size() > 0);
      push_req = retire && !abort && ((st0 == 2) || (st0 == 1 && pc_in == trig_pc));
      accept   = 1'b0;
      if (push_req) begin
        if (pop_ok) begin
          void'(mq[k].pop_front());
          accept = 1'b1;
        end else if (mq[k].size() < dep_of(k)) begin
          accept = 1'b1;
        end else if (wrap_of(k) != 0) begin
          void'(mq[k].pop_front());
          m_ovf[k] = 1'b1;
          accept = 1'b1;
        end else begin
          m_ovf[k]   = 1'b1;
          m_state[k] = 3;
        end
        if (accept) begin
          mq[k].push_back(r);
          if (m_cnt[k] < 65535) m_cnt[k]++;
          m_state[k] = (cap_len != 0 && m_cnt[k] == int'(cap_len)) ? 3 : 2;
        end
      end else if (pop_ok) begin
        void'(mq[k].pop_front());
      end
      if (abort) m_state[k] = 0;
      else if (arm && (st0 == 0 || st0 == 3)) begin
        m_state[k] = 1;
        m_cnt[k]   = 0;
        m_ovf[k]   = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    trace_rec_t h;
    bit v;
    for (int k = 0; k < ND; k++) begin
      v = (mq[k].size() != 0);
      h = v ? mq[k][0] : '0;
      chk($sformatf("d%0d.valid", k), 64'(o_valid[k]), 64'(v));
      chk($sformatf("d%0d.pc", k),    64'(o_pc[k]),    64'(h.pc));
      chk($sformatf("d%0d.instr", k), 64'(o_instr[k]), 64'(h.instr));
      chk($sformatf("d%0d.we", k),    64'(o_we[k]),    64'(h.dm_we));
      chk($sformatf("d%0d.addr", k),  64'(o_addr[k]),  64'(h.dm_addr));
      chk($sformatf("d%0d.wdata", k), 64'(o_wdata[k]), 64'(h.dm_wdata));
      chk($sformatf("d%0d.state", k), 64'(o_state[k]), 64'(m_state[k]));
      chk($sformatf("d%0d.ovf", k),   64'(o_ovf[k]),   64'(m_ovf[k]));
      chk($sformatf("d%0d.count", k), 64'(o_cnt[k]),   64'(mq[k].size()));
    end
  endtask

  // Inputs are set just after a falling edge; the model predicts the next
  // rising edge and the outputs are compared at the following falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  logic [31:0] p_pc   [15];
  logic [31:0] p_ins  [15];
  logic        p_we   [15];
  logic [31:0] p_addr [15];
  logic [31:0] p_data [15];

  task automatic run_prog();
    for (int i = 0; i < 15; i++) begin
      retire = 1'b1; pc_in = p_pc[i]; instr_in = p_ins[i]; dm_we_in = p_we[i];
      dm_addr_in = p_addr[i]; dm_wdata_in = p_data[i];
      tick();
    end
    retire = 1'b0;
  endtask

  task automatic retire_pc(input logic [31:0] pc);
    retire = 1'b1; pc_in = pc; instr_in = $urandom; dm_we_in = 1'(($urandom_range(0, 1)));
    dm_addr_in = $urandom; dm_wdata_in = $urandom;
    tick();
    retire = 1'b0;
  endtask

  initial begin
    p_pc  = '{32'h00, 32'h04, 32'h08, 32'h0c, 32'h10, 32'h14, 32'h18, 32'h1c,
              32'h20, 32'h28, 32'h2c, 32'h30, 32'h34, 32'h38, 32'h44};
    p_ins = '{32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824,
              32'h00a42820, 32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h00e2202a,
              32'h00853820, 32'h00e23822, 32'hac670044, 32'h8c020050, 32'hac020054};
    for (int i = 0; i < 15; i++) begin
      p_we[i] = 1'b0; p_addr[i] = $urandom; p_data[i] = $urandom;
    end
    p_we[12] = 1'b1; p_addr[12] = 32'd80; p_data[12] = 32'd7;
    p_we[14] = 1'b1; p_addr[14] = 32'd84; p_data[14] = 32'd7;

    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Whole program traced, drained as it goes.
    trig_pc = 32'h0; cap_len = 16'd0; rd_ready = 1'b1; arm = 1'b1; tick(); arm = 1'b0;
    run_prog();
    chk("prog.last_instr", 64'(o_instr[0]), 64'h0000_0000_ac02_0054);
    chk("prog.last_we",    64'(o_we[0]),    64'd1);
    chk("prog.last_addr",  64'(o_addr[0]),  64'd84);
    chk("prog.last_wdata", 64'(o_wdata[0]), 64'd7);
    chk("prog.ovf",        64'(o_ovf[0]),   64'd0);

    // Trigger at 0x10, three records.
    abort = 1'b1; tick(); abort = 1'b0; rd_ready = 1'b0;
    trig_pc = 32'h10; cap_len = 16'd3; arm = 1'b1; tick(); arm = 1'b0;
    run_prog();
    chk("cap3.state", 64'(o_state[0]), 64'd3);
    chk("cap3.count", 64'(o_cnt[0]),   64'd3);
    chk("cap3.head",  64'(o_pc[0]),    64'h10);

    // Six retires into 4-deep FIFOs, with and without wrap.
    abort = 1'b1; rd_ready = 1'b1; repeat (4) tick(); abort = 1'b0; rd_ready = 1'b0;
    cap_len = 16'd0; arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 6; i++) retire_pc(32'h10 + 32'(4 * i));
    chk("nowrap.count", 64'(o_cnt[1]),   64'd4);
    chk("nowrap.ovf",   64'(o_ovf[1]),   64'd1);
    chk("nowrap.state", 64'(o_state[1]), 64'd3);
    chk("nowrap.head",  64'(o_pc[1]),    64'h10);
    chk("wrap.count",   64'(o_cnt[2]),   64'd4);
    chk("wrap.ovf",     64'(o_ovf[2]),   64'd1);
    chk("wrap.head",    64'(o_pc[2]),    64'h18);

    // Full FIFO with simultaneous push and pop.
    abort = 1'b1; rd_ready = 1'b1; repeat (8) tick(); abort = 1'b0; rd_ready = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int i = 0; i < 4; i++) retire_pc(32'h10 + 32'(4 * i));
    chk("full.count", 64'(o_cnt[1]), 64'd4);
    rd_ready = 1'b1; retire_pc(32'h20); rd_ready = 1'b0;
    chk("pushpop.count", 64'(o_cnt[1]), 64'd4);
    chk("pushpop.ovf",   64'(o_ovf[1]), 64'd0);
    chk("pushpop.head",  64'(o_pc[1]),  64'h14);
    chk("pushpop.wcnt",  64'(o_cnt[2]), 64'd4);

    // Reset mid-capture, then abort from ARMED keeps the FIFO.
    retire_pc(32'h24);
    do_reset();
    chk("rst.state", 64'(o_state[0]), 64'd0);
    chk("rst.count", 64'(o_cnt[2]),   64'd0);
    trig_pc = 32'h0; cap_len = 16'd2; arm = 1'b1; tick(); arm = 1'b0;
    retire_pc(32'h0); retire_pc(32'h4);
    chk("cap2.state", 64'(o_state[0]), 64'd3);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("rearm.state", 64'(o_state[0]), 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort.state", 64'(o_state[0]), 64'd0);
    chk("abort.count", 64'(o_cnt[0]),   64'd2);
    chk("abort.head",  64'(o_pc[0]),    64'h0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      retire      = ($urandom_range(0, 9) < 7);
      pc_in       = 32'($urandom_range(0, 15)) * 4;
      instr_in    = $urandom;
      dm_we_in    = 1'($urandom_range(0, 1));
      dm_addr_in  = $urandom;
      dm_wdata_in = $urandom;
      rd_ready    = ($urandom_range(0, 9) < 4);
      arm         = ($urandom_range(0, 19) == 0);
      abort       = !retire && ($urandom_range(0, 49) == 0);
      if (arm) begin
        trig_pc = 32'($urandom_range(0, 15)) * 4;
        cap_len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(2, 8));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
